// File: rtl/ahb_master_pkg.sv
// Shared AHB-Lite master types: transfer encodings, burst/size codes and FSM states.
// Pure declarations; no timing or backpressure of its own.
package ahb_master_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_BURST,
    S_LAST,
    S_ERR
  } state_t;

endpackage

// File: rtl/ahb_lite_master_if.sv
// Command/beat-data side and AHB-Lite bus side of the master in one bundle.
// master modport is the design view; slave modport is the command source plus AHB slave view.
interface ahb_lite_master_if #(
  parameter int AddrBusWidth = 32,
  parameter int DataBusWidth = 32
) ();
  import ahb_master_pkg::*;

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_write;
  logic [AddrBusWidth-1:0] cmd_addr;
  logic [3:0]              cmd_len;
  logic [DataBusWidth-1:0] wr_data;
  logic                    wr_pop;
  logic [DataBusWidth-1:0] rd_data;
  logic                    rd_valid;
  logic                    done;
  logic                    error;

  logic [AddrBusWidth-1:0] HADDR;
  htrans_t                 HTRANS;
  logic                    HWRITE;
  logic [2:0]              HSIZE;
  logic [2:0]              HBURST;
  logic [DataBusWidth-1:0] HWDATA;
  logic [DataBusWidth-1:0] HRDATA;
  logic                    HREADY;
  logic                    HRESP;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, HRDATA, HREADY, HRESP,
    output cmd_ready, wr_pop, rd_data, rd_valid, done, error,
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, HRDATA, HREADY, HRESP,
    input  cmd_ready, wr_pop, rd_data, rd_valid, done, error,
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA
  );

endinterface

// File: rtl/ahb_master_beat_ctr.sv
// Beats-remaining counter, next word address and 1 KB boundary flag for the burst in flight.
// Counter loads on command accept and steps once per completed address phase.
module ahb_master_beat_ctr #(
  parameter int AddrBusWidth = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [3:0]              len,
  input  logic                    step,
  input  logic [AddrBusWidth-1:0] addr,
  output logic                    last_beat,
  output logic [AddrBusWidth-1:0] next_addr,
  output logic                    cross_1k
);

  logic [3:0] remain;

  always_ff @(posedge clk) begin
    if (rst) begin
      remain <= 4'd0;
    end else if (load) begin
      remain <= len;
    end else if (step && remain != 4'd0) begin
      remain <= remain - 4'd1;
    end
  end

  assign last_beat = (remain == 4'd0);
  assign next_addr = addr + AddrBusWidth'(4);
  // A wrap of the low 10 bits means the next beat opens a new 1 KB page.
  assign cross_1k  = (next_addr[9:0] == 10'd0);

endmodule

// File: rtl/ahb_lite_master.sv
// AHB-Lite master: one command -> SINGLE or INCR word burst (INCR only with AHB_MASTER_INCR_BURST_EN).
// NONSEQ one cycle after accept; cmd_ready only in IDLE; beats stall on HREADY=0.
module ahb_lite_master
  import ahb_master_pkg::*;
#(
  parameter int AddrBusWidth = 32,
  parameter int DataBusWidth = 32
) (
  input logic               HCLK,
  input logic               HRESET,
  ahb_lite_master_if.master bus
);

  state_t                  state;
  htrans_t                 htrans_q;
  logic                    dph_vld;
  logic                    dph_write;
  logic [3:0]              len_eff;
  logic                    addr_step;
  logic                    err_first;
  logic                    last_beat;
  logic                    cross_1k;
  logic [AddrBusWidth-1:0] next_addr;

`ifdef AHB_MASTER_INCR_BURST_EN
  assign len_eff = bus.cmd_len;
`else
  logic unused_len;
  assign unused_len = ^bus.cmd_len;
  assign len_eff    = 4'd0;
`endif

  assign addr_step = (state == S_ADDR || state == S_BURST) && bus.HREADY;
  // First ERROR cycle withdraws any pending address phase combinationally.
  assign err_first = dph_vld && bus.HRESP && !bus.HREADY;

  assign bus.HTRANS    = err_first ? HTRANS_IDLE : htrans_q;
  assign bus.HSIZE     = HSIZE_WORD;
  assign bus.wr_pop    = addr_step && bus.HWRITE && !HRESET;
  assign bus.cmd_ready = (state == S_IDLE);

  ahb_master_beat_ctr #(.AddrBusWidth(AddrBusWidth)) u_beat_ctr (
    .clk       (HCLK),
    .rst       (HRESET),
    .load      ((state == S_IDLE) && bus.cmd_valid),
    .len       (len_eff),
    .step      (addr_step),
    .addr      (bus.HADDR),
    .last_beat (last_beat),
    .next_addr (next_addr),
    .cross_1k  (cross_1k)
  );

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state        <= S_IDLE;
      htrans_q     <= HTRANS_IDLE;
      dph_vld      <= 1'b0;
      dph_write    <= 1'b0;
      bus.HADDR    <= '0;
      bus.HWRITE   <= 1'b0;
      bus.HBURST   <= HBURST_SINGLE;
      bus.HWDATA   <= '0;
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
      bus.done     <= 1'b0;
      bus.error    <= 1'b0;
    end else begin
      bus.rd_valid <= 1'b0;
      bus.done     <= 1'b0;
      bus.error    <= 1'b0;
      if (dph_vld && bus.HREADY && !dph_write && !bus.HRESP) begin
        bus.rd_data  <= bus.HRDATA;
        bus.rd_valid <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            state      <= S_ADDR;
            htrans_q   <= HTRANS_NONSEQ;
            bus.HADDR  <= bus.cmd_addr;
            bus.HWRITE <= bus.cmd_write;
            bus.HBURST <= (len_eff != 4'd0) ? HBURST_INCR : HBURST_SINGLE;
          end
        end
        S_ADDR, S_BURST: begin
          if (err_first) begin
            state    <= S_ERR;
            htrans_q <= HTRANS_IDLE;
          end else if (bus.HREADY) begin
            dph_vld   <= 1'b1;
            dph_write <= bus.HWRITE;
            if (bus.HWRITE) begin
              bus.HWDATA <= bus.wr_data;
            end
            if (last_beat) begin
              state    <= S_LAST;
              htrans_q <= HTRANS_IDLE;
            end else begin
              state     <= S_BURST;
              bus.HADDR <= next_addr;
              htrans_q  <= cross_1k ? HTRANS_NONSEQ : HTRANS_SEQ;
            end
          end
        end
        S_LAST: begin
          if (err_first) begin
            state <= S_ERR;
          end else if (bus.HREADY) begin
            dph_vld  <= 1'b0;
            bus.done <= 1'b1;
            state    <= S_IDLE;
          end
        end
        S_ERR: begin
          if (bus.HREADY) begin
            dph_vld   <= 1'b0;
            bus.done  <= 1'b1;
            bus.error <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Drives commands into ahb_lite_master while acting as a memory-like AHB slave with wait states
// and an ERROR region at 0x800 and above; every beat is compared against a spec-level model.
module tb_ahb_lite_master;
  import ahb_master_pkg::*;

  logic HCLK;
  logic HRESET;
  int   n_pass  = 0;
  int   n_total = 0;

  ahb_lite_master_if #(.AddrBusWidth(32), .DataBusWidth(32)) bus ();

  ahb_lite_master #(.AddrBusWidth(32), .DataBusWidth(32)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int nbeats(input logic [3:0] l);
`ifdef AHB_MASTER_INCR_BURST_EN
    return int'(l) + 1;
`else
    return 1;
`endif
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] ad, input logic [31:0] s);
    return {ad[15:0], ~ad[15:0]} ^ s;
  endfunction

  // One command end to end; wb/wc = beat index whose data phase stalls and stall length.
  task automatic run_cmd(input bit w, input logic [31:0] a, input logic [3:0] l,
                         input int wb, input int wc, input logic [31:0] first_wd);
    int          nb, n_addr, n_pop, cyc, done_cyc, first_cyc, pend_idx, waits_left;
    bit          err, pend_vld, pend_write, err_stage, hold_vld, done_seen;
    logic [31:0] pend_addr, hold_addr, salt, ea;
    logic [2:0]  exp_burst;
    logic [31:0] wq[$];
    logic [31:0] got_wr[$];
    logic [31:0] got_rd[$];
    nb = nbeats(l);
    err = (a >= 32'h800);
    exp_burst = (nb > 1) ? HBURST_INCR : HBURST_SINGLE;
    salt = $urandom;
    wq.push_back(first_wd);
    for (int i = 1; i < nb; i++) wq.push_back($urandom);
    n_addr = 0; n_pop = 0; cyc = 0; done_cyc = 0; first_cyc = 0; pend_idx = 0;
    waits_left = wc; pend_vld = 0; pend_write = 0; err_stage = 0; hold_vld = 0;
    done_seen = 0; pend_addr = 0; hold_addr = 0;

    @(negedge HCLK);
    bus.cmd_valid = 1'b1; bus.cmd_write = w; bus.cmd_addr = a; bus.cmd_len = l;
    bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.wr_data = wq[0];
    #1;
    check("cmd_ready", bus.cmd_ready, 1);
    @(posedge HCLK);

    while (!done_seen && cyc < 100) begin
      @(negedge HCLK);
      cyc++;
      bus.cmd_valid = 1'b0; bus.cmd_write = 1'($urandom);
      bus.cmd_addr = $urandom; bus.cmd_len = 4'($urandom);
      bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = $urandom;
      if (pend_vld) begin
        if (pend_addr >= 32'h800) begin
          bus.HRESP = 1'b1;
          bus.HREADY = err_stage;
        end else if (pend_idx == wb && waits_left > 0) begin
          bus.HREADY = 1'b0;
          waits_left--;
        end
        if (!pend_write) bus.HRDATA = rd_word(pend_addr, salt);
      end
      bus.wr_data = (n_pop < nb) ? wq[n_pop] : $urandom;
      #1;
      if (hold_vld) begin
        check("addr_hold", bus.HADDR, hold_addr);
        hold_vld = 0;
      end
      if (bus.HRESP && !bus.HREADY) check("err_htrans_idle", bus.HTRANS, HTRANS_IDLE);
      if (bus.wr_pop) n_pop++;
      if (bus.rd_valid) got_rd.push_back(bus.rd_data);
      if (bus.done) begin
        done_seen = 1;
        done_cyc = cyc;
        check("error_flag", bus.error, err);
      end
      // Slave's view of the coming clock edge.
      if (pend_vld && bus.HREADY) begin
        if (pend_write && !bus.HRESP) got_wr.push_back(bus.HWDATA);
        pend_vld = 0;
        err_stage = 0;
      end else if (pend_vld && bus.HRESP) begin
        err_stage = 1;
      end
      if (bus.HTRANS[1] && !bus.HREADY && !bus.HRESP) begin
        hold_vld = 1;
        hold_addr = bus.HADDR;
      end
      if (bus.HTRANS[1] && bus.HREADY) begin
        ea = a + 32'(4 * n_addr);
        if (n_addr == 0) first_cyc = cyc;
        if (n_addr < nb) begin
          check("haddr", bus.HADDR, ea);
          check("htrans", bus.HTRANS,
                (n_addr == 0 || ea[9:0] == 10'd0) ? HTRANS_NONSEQ : HTRANS_SEQ);
          check("hburst", bus.HBURST, exp_burst);
          check("hsize", bus.HSIZE, 3'b010);
          check("hwrite", bus.HWRITE, w);
        end
        pend_vld = 1; pend_addr = bus.HADDR; pend_write = bus.HWRITE;
        pend_idx = n_addr; n_addr++;
      end
    end

    check("done_seen", done_seen, 1);
    check("done_cycle", done_cyc, err ? 4 : nb + 2 + ((wb < nb) ? wc : 0));
    check("first_nonseq_cycle", first_cyc, 1);
    check("addr_beats", n_addr, err ? 1 : nb);
    check("wr_pop_count", n_pop, w ? (err ? 1 : nb) : 0);
    check("rd_count", got_rd.size(), (w || err) ? 0 : nb);
    for (int i = 0; i < got_rd.size() && i < nb; i++)
      check("rd_data", got_rd[i], rd_word(a + 32'(4 * i), salt));
    check("wr_count", got_wr.size(), (w && !err) ? nb : 0);
    for (int i = 0; i < got_wr.size() && i < nb; i++)
      check("hwdata", got_wr[i], wq[i]);

    @(negedge HCLK);
    bus.HREADY = 1'b1; bus.HRESP = 1'b0;
    #1;
    check("ready_after", bus.cmd_ready, 1);
    check("idle_after", bus.HTRANS, HTRANS_IDLE);
    check("done_pulse", bus.done, 0);
  endtask

  initial begin
    bit          w;
    logic [31:0] a;
    logic [3:0]  l;
    int          sel;

    HRESET = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wr_data = '0; bus.HRDATA = '0; bus.HREADY = 1'b1; bus.HRESP = 1'b0;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
    #1;
    check("rst_htrans", bus.HTRANS, HTRANS_IDLE);
    check("rst_haddr", bus.HADDR, 0);
    check("rst_hwrite", bus.HWRITE, 0);
    check("rst_hburst", bus.HBURST, 0);
    check("rst_hwdata", bus.HWDATA, 0);
    check("rst_rd_data", bus.rd_data, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_done", bus.done, 0);
    check("rst_error", bus.error, 0);
    check("rst_wr_pop", bus.wr_pop, 0);
    check("rst_cmd_ready", bus.cmd_ready, 1);

    run_cmd(1'b1, 32'h004, 4'd0, 9, 0, 32'hA5A5_0001);
    run_cmd(1'b0, 32'h100, 4'd3, 1, 2, $urandom);
    run_cmd(1'b1, 32'h3F8, 4'd3, 9, 0, $urandom);
    run_cmd(1'b0, 32'h900, 4'd0, 9, 0, $urandom);
    run_cmd(1'b1, 32'hA00, 4'd2, 9, 0, $urandom);
    run_cmd(1'b0, 32'h040, 4'd5, 9, 0, $urandom);

    for (int k = 0; k < 14; k++) begin
      w = 1'($urandom);
      l = 4'($urandom);
      sel = $urandom_range(0, 3);
      case (sel)
        0:       a = 32'h400 - 32'(4 * $urandom_range(1, 6));
        1:       a = 32'h800 + 32'(4 * $urandom_range(0, 255));
        default: a = 32'(4 * $urandom_range(0, 480));
      endcase
      run_cmd(w, a, l, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    // Reset while a long read burst is in flight.
    @(negedge HCLK);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h200; bus.cmd_len = 4'd7;
    bus.HREADY = 1'b1; bus.HRESP = 1'b0;
    @(negedge HCLK);
    bus.cmd_valid = 1'b0;
    #1;
    check("rstb_nonseq", bus.HTRANS, HTRANS_NONSEQ);
    @(negedge HCLK);
    HRESET = 1'b1;
    @(negedge HCLK);
    HRESET = 1'b0;
    #1;
    check("rstb_htrans", bus.HTRANS, HTRANS_IDLE);
    check("rstb_cmd_ready", bus.cmd_ready, 1);
    check("rstb_done", bus.done, 0);
    check("rstb_haddr", bus.HADDR, 0);
    repeat (4) begin
      @(negedge HCLK);
      #1;
      check("rstb_no_done", bus.done, 0);
      check("rstb_no_rd_valid", bus.rd_valid, 0);
      check("rstb_idle", bus.HTRANS, HTRANS_IDLE);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
